multicycle_control_fsm: RTL

//  Multi-cycle sequencer for the RV32I core datapath. It walks each instruction through FETCH,

---
 rtl/multicycle_control_fsm_pkg.sv | 46 ++++
 rtl/multicycle_control_fsm_if.sv | 36 +++
 rtl/multicycle_control_fsm_mem_wait_timer.sv | 39 +++
 rtl/multicycle_control_fsm.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared control definitions for the RV32I multi-cycle core.
// Holds the sequencer state encoding, the major opcodes and the ALU/immediate selects.
// The immediate generator decodes its formats with these same constants.
package core_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_ADDR,
      S_MEM_RD,
      S_MEM_WR,
      S_WB_ALU,
      S_WB_MEM,
      S_BRANCH,
      S_TRAP
   } state_e;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;

   typedef enum logic [1:0] {
      IMM_I  = 2'b00,
      IMM_S  = 2'b01,
      IMM_SB = 2'b10
   } imm_sel_e;

   typedef enum logic [1:0] {
      ALU_ADD   = 2'b00,
      ALU_SUB   = 2'b01,
      ALU_FUNCT = 2'b10
   } alu_op_e;

   // States that hold a memory request open and are guarded by the wait timer.
   function automatic logic is_wait_state(input state_e s);
      return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
   endfunction

endpackage

// File: rtl/multicycle_control_fsm_if.sv
// Control bundle between the sequencer and the datapath.
// master = sequencer (drives strobes), slave = datapath/memory (drives IR fields, flags, ready).
interface multicycle_control_fsm_if;
   import core_pkg::*;

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       zero;
   logic       mem_ready;

   logic       mem_req;
   logic       mem_we;
   logic       ir_write;
   logic       pc_write;
   logic       pc_src;
   logic       reg_write;
   logic       wb_sel;
   logic       alu_src_b;
   alu_op_e    alu_op;
   imm_sel_e   imm_sel;
   logic       illegal;
   logic       timeout;

   modport master (
      input  opcode, funct3, zero, mem_ready,
      output mem_req, mem_we, ir_write, pc_write, pc_src, reg_write,
             wb_sel, alu_src_b, alu_op, imm_sel, illegal, timeout
   );

   modport slave (
      output opcode, funct3, zero, mem_ready,
      input  mem_req, mem_we, ir_write, pc_write, pc_src, reg_write,
             wb_sel, alu_src_b, alu_op, imm_sel, illegal, timeout
   );

endinterface

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready in a memory state.
// at_limit flags the last allowed waiting cycle; the sequencer decides what to do with it.
module mem_wait_timer #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic count_en,
   output logic at_limit
);

   localparam int CW = $clog2(TIMEOUT_CYCLES);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   assign at_limit = (count_q == CW'(TIMEOUT_CYCLES - 1));

   // Clear on state entry, otherwise count waiting cycles; saturate at the limit.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (count_en && !at_limit) begin
         count_d = count_q + CW'(1);
      end
   end

   // Counter register.
   always_ff @(posedge clk) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH -> DECODE -> EXEC/ADDR/BRANCH -> MEM -> WB.
// Strobes are state-decoded; only the FETCH/WB_MEM handshakes and branch outcome qualify them.
module multicycle_control_fsm
   import core_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   multicycle_control_fsm_if.master bus
);

   state_e state_q;
   state_e state_d;
   logic   illegal_q;
   logic   illegal_d;
   logic   timeout_q;
   logic   timeout_d;

   logic   wait_clear;
   logic   wait_count_en;
   logic   wait_at_limit;
   logic   branch_ok;
   logic   branch_taken;

   // Only beq/bne are supported branch forms.
   assign branch_ok    = (bus.funct3 == F3_BEQ) || (bus.funct3 == F3_BNE);
   assign branch_taken = ((bus.funct3 == F3_BEQ) &&  bus.zero) ||
                         ((bus.funct3 == F3_BNE) && !bus.zero);

   // Any state change restarts the wait count, so each wait state starts from zero.
   assign wait_clear    = (state_d != state_q);
   assign wait_count_en = is_wait_state(state_q) && !bus.mem_ready;

   mem_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_wait_timer (
      .clk      (clk),
      .reset    (reset),
      .clear    (wait_clear),
      .count_en (wait_count_en),
      .at_limit (wait_at_limit)
   );

   // State and sticky-flag registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
      end
   end

   // Next-state selection; mem_ready on the limit cycle wins over the timeout.
   always_comb begin
      state_d   = state_q;
      illegal_d = illegal_q;
      timeout_d = timeout_q;
      case (state_q)
         S_FETCH: begin
            if (bus.mem_ready) begin
               state_d = S_DECODE;
            end else if (wait_at_limit) begin
               state_d   = S_TRAP;
               timeout_d = 1'b1;
            end
         end
         S_DECODE: begin
            case (bus.opcode)
               OP_R:              state_d = S_EXEC_R;
               OP_IMM:            state_d = S_EXEC_I;
               OP_LOAD, OP_STORE: state_d = S_ADDR;
               OP_BRANCH:         state_d = S_BRANCH;
               default: begin
                  state_d   = S_TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
         S_ADDR: state_d = (bus.opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD: begin
            if (bus.mem_ready) begin
               state_d = S_WB_MEM;
            end else if (wait_at_limit) begin
               state_d   = S_TRAP;
               timeout_d = 1'b1;
            end
         end
         S_MEM_WR: begin
            if (bus.mem_ready) begin
               state_d = S_FETCH;
            end else if (wait_at_limit) begin
               state_d   = S_TRAP;
               timeout_d = 1'b1;
            end
         end
         S_WB_ALU, S_WB_MEM: state_d = S_FETCH;
         S_BRANCH: begin
            if (branch_ok) begin
               state_d = S_FETCH;
            end else begin
               state_d   = S_TRAP;
               illegal_d = 1'b1;
            end
         end
         S_TRAP:  state_d = S_TRAP;
         default: state_d = S_FETCH;
      endcase
   end

   // Output decode from the current state; everything forced low while reset is held.
   always_comb begin
      bus.mem_req   = 1'b0;
      bus.mem_we    = 1'b0;
      bus.ir_write  = 1'b0;
      bus.pc_write  = 1'b0;
      bus.pc_src    = 1'b0;
      bus.reg_write = 1'b0;
      bus.wb_sel    = 1'b0;
      bus.alu_src_b = 1'b0;
      bus.alu_op    = ALU_ADD;
      bus.imm_sel   = IMM_I;
      case (state_q)
         S_FETCH: begin
            bus.mem_req  = 1'b1;
            bus.ir_write = bus.mem_ready;
            bus.pc_write = bus.mem_ready;
         end
         S_EXEC_R: begin
            bus.alu_op = ALU_FUNCT;
         end
         S_EXEC_I: begin
            bus.alu_src_b = 1'b1;
            bus.alu_op    = ALU_FUNCT;
         end
         S_ADDR: begin
            bus.alu_src_b = 1'b1;
            bus.imm_sel   = (bus.opcode == OP_STORE) ? IMM_S : IMM_I;
         end
         S_MEM_RD: begin
            bus.mem_req = 1'b1;
         end
         S_MEM_WR: begin
            bus.mem_req = 1'b1;
            bus.mem_we  = 1'b1;
         end
         S_WB_ALU: begin
            bus.reg_write = 1'b1;
         end
         S_WB_MEM: begin
            // Load data is only trusted while memory still presents it.
            bus.reg_write = bus.mem_ready;
            bus.wb_sel    = 1'b1;
         end
         S_BRANCH: begin
            bus.imm_sel  = IMM_SB;
            bus.alu_op   = ALU_SUB;
            bus.pc_src   = 1'b1;
            bus.pc_write = branch_ok && branch_taken;
         end
         default: ;
      endcase
      if (reset) begin
         bus.mem_req   = 1'b0;
         bus.mem_we    = 1'b0;
         bus.ir_write  = 1'b0;
         bus.pc_write  = 1'b0;
         bus.pc_src    = 1'b0;
         bus.reg_write = 1'b0;
         bus.wb_sel    = 1'b0;
         bus.alu_src_b = 1'b0;
         bus.alu_op    = ALU_ADD;
         bus.imm_sel   = IMM_I;
      end
   end

   assign bus.illegal = illegal_q && !reset;
   assign bus.timeout = timeout_q && !reset;

endmodule
